// File: rtl/serial_tx_if.sv
// Producer-side handshake and serial line for the serial_tx framer.
interface serial_tx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 tx;
   logic                 busy;
   logic                 done;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx, busy, done
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx, busy, done
   );
endinterface

// File: rtl/serial_tx.sv
// UART-style framer: start bit, DATA_BITS payload LSB first, stop bit; all outputs registered.
//  state | meaning
//  IDLE  | line high, ready for a byte; first IDLE cycle after a frame carries done
//  START | start bit (line low)
//  DATA  | payload bits, LSB first
//  STOP  | stop bit (line high)
module serial_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8
) (
   input logic        clk,
   input logic        clr,
   serial_tx_if.slave bus
);

   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                r_state;
   logic [DIV_W-1:0]      r_div;
   logic [BIT_W-1:0]      r_bit_idx;
   logic [DATA_BITS-1:0]  r_shreg;
   logic                  r_tx;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_done;

   state_t                w_state_nx;
   logic [DIV_W-1:0]      w_div_nx;
   logic [BIT_W-1:0]      w_bit_nx;
   logic [DATA_BITS-1:0]  w_shreg_nx;
   logic                  w_tx_nx;
   logic                  w_ready_nx;
   logic                  w_busy_nx;
   logic                  w_done_nx;
   logic                  w_bit_end;
   logic [DATA_BITS-1:0]  w_shifted;

   assign w_bit_end = (r_div == DIV_LAST);
   assign w_shifted = r_shreg >> 1;

   always_comb begin
      w_state_nx = r_state;
      w_div_nx   = r_div;
      w_bit_nx   = r_bit_idx;
      w_shreg_nx = r_shreg;
      w_tx_nx    = r_tx;
      w_ready_nx = r_ready;
      w_busy_nx  = r_busy;
      w_done_nx  = 1'b0;
      case (r_state)
         IDLE: begin
            w_tx_nx    = 1'b1;
            w_ready_nx = 1'b1;
            w_busy_nx  = 1'b0;
            w_div_nx   = '0;
            w_bit_nx   = '0;
            if (bus.tx_valid && r_ready) begin
               w_state_nx = START;
               w_shreg_nx = bus.tx_data;
               w_tx_nx    = 1'b0;
               w_ready_nx = 1'b0;
               w_busy_nx  = 1'b1;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_div_nx   = '0;
               w_state_nx = DATA;
               w_tx_nx    = r_shreg[0];
            end else begin
               w_div_nx = r_div + DIV_W'(1);
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_div_nx = '0;
               if (r_bit_idx == BIT_LAST) begin
                  w_state_nx = STOP;
                  w_bit_nx   = '0;
                  w_tx_nx    = 1'b1;
               end else begin
                  w_bit_nx   = r_bit_idx + BIT_W'(1);
                  w_shreg_nx = w_shifted;
                  w_tx_nx    = w_shifted[0];
               end
            end else begin
               w_div_nx = r_div + DIV_W'(1);
            end
         end
         STOP: begin
            if (w_bit_end) begin
               // ready rises together with done so a held byte goes out with no extra gap
               w_div_nx   = '0;
               w_state_nx = IDLE;
               w_done_nx  = 1'b1;
               w_ready_nx = 1'b1;
               w_busy_nx  = 1'b0;
            end else begin
               w_div_nx = r_div + DIV_W'(1);
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_div_nx   = '0;
            w_bit_nx   = '0;
            w_tx_nx    = 1'b1;
            w_ready_nx = 1'b1;
            w_busy_nx  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state   <= IDLE;
         r_div     <= '0;
         r_bit_idx <= '0;
         r_shreg   <= '0;
         r_tx      <= 1'b1;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_div     <= w_div_nx;
         r_bit_idx <= w_bit_nx;
         r_shreg   <= w_shreg_nx;
         r_tx      <= w_tx_nx;
         r_ready   <= w_ready_nx;
         r_busy    <= w_busy_nx;
         r_done    <= w_done_nx;
      end
   end

   assign bus.tx       = r_tx;
   assign bus.tx_ready = r_ready;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx with CLKS_PER_BIT=4, DATA_BITS=8; status nibble = {busy,done,tx_ready,tx}.
module tb_serial_tx;

   logic clk;
   logic clr;
   int   total;
   int   bad;
   int   cyc;
   int   t_done;
   int   t_acc;
   int   t_first;

   serial_tx_if #(.DATA_BITS(8)) bus ();

   serial_tx #(
      .CLKS_PER_BIT(4),
      .DATA_BITS   (8)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] status();
      return {bus.busy, bus.done, bus.tx_ready, bus.tx};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Call right after the accept edge; walks the 40 frame cycles, then the done cycle.
   task automatic run_frame(input logic [7:0] b, input bit hold, input string tag);
      logic [3:0] e;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k <= 4)       e = 4'b1000;
         else if (k <= 36) e = {3'b100, b[(k-5)/4]};
         else              e = 4'b1001;
         chk($sformatf("%s_c%0d", tag, k), 32'(status()), 32'(e));
         if (k == 1 && !hold) bus.tx_valid = 1'b0;
         if (k == 10 && hold) bus.tx_data = ~bus.tx_data;
      end
      @(negedge clk);
      chk({tag, "_done"}, 32'(status()), 32'(4'b0111));
      t_done = cyc;
   endtask

   initial begin
      clk = 1'b0;
      clr = 1'b0;
      cyc = 0;
      total = 0;
      bad = 0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;

      #2 clr = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_init", 32'(status()), 32'(4'b0011));
      clr = 1'b0;
      @(negedge clk);
      chk("idle_after_rst", 32'(status()), 32'(4'b0011));

      // 0xA5 frame and accept-to-done latency
      bus.tx_data  = 8'hA5;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1 t_acc = cyc;
      run_frame(8'hA5, 1'b0, "a5");
      chk("a5_latency", 32'(t_done - t_acc), 32'd40);
      @(negedge clk);
      chk("a5_after_done", 32'(status()), 32'(4'b0011));

      // asynchronous clr during the start bit
      bus.tx_data  = 8'h55;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      chk("mid_start", 32'(status()), 32'(4'b1000));
      #2 clr = 1'b1;
      #1 chk("clr_async", 32'(status()), 32'(4'b0011));
      @(negedge clk);
      chk("clr_held", 32'(status()), 32'(4'b0011));
      clr = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("clr_released", 32'(status()), 32'(4'b0011));
      end

      // held tx_valid, tx_data changed mid-frame; the new byte goes out in the done cycle
      bus.tx_data  = 8'h5A;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      run_frame(8'h5A, 1'b1, "hold");
      run_frame(8'hA5, 1'b0, "held");
      @(negedge clk);
      chk("held_idle", 32'(status()), 32'(4'b0011));

      // back-to-back 0x00 then 0xFF
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      run_frame(8'h00, 1'b0, "b2b0");
      t_first = t_done;
      bus.tx_data  = 8'hFF;
      bus.tx_valid = 1'b1;
      run_frame(8'hFF, 1'b0, "b2b1");
      // 40 frame cycles plus the single done/accept cycle between frames
      chk("b2b_done_gap", 32'(t_done - t_first), 32'd41);

      // clr during data bit 3 of 0x3C, then a clean 0x81 frame
      bus.tx_data  = 8'h3C;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 1) bus.tx_valid = 1'b0;
      end
      chk("bit3_before_clr", 32'(status()), 32'(4'b1001));
      #2 clr = 1'b1;
      #1 chk("bit3_clr_async", 32'(status()), 32'(4'b0011));
      @(negedge clk);
      clr = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         chk("abandoned_no_done", 32'(status()), 32'(4'b0011));
      end
      bus.tx_data  = 8'h81;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      run_frame(8'h81, 1'b0, "x81");

      // long idle with tx_valid low
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         chk("idle100", 32'(status()), 32'(4'b0011));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
